ex_stage: RTL and testbench

//  Execute stage directly downstream of the decode stage (id); consumes id's aluop/alusel/reg1/reg2/wd/wreg
//  via the id/ex register and produces the GPR write-back tuple plus a HI/LO write for the ex/mem register.

---
 rtl/ex_stage_if.sv | 28 ++
 rtl/ex_stage.sv | 181 ++++++++++++++++++
 tb/tb_ex_stage.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Bundle between the id/ex register and the execute stage: operands in, write-back tuple,
// HI/LO write and stall request out.
interface ex_stage_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/arithmetic ALU plus a 32-step restoring divider
// that stalls the front of the pipeline until the HI/LO result is ready.
module ex_stage #(
  parameter int DIV_STEPS = 32
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave ex
);

  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV_ZERO,
    DIV_ON,
    DIV_END
  } div_state_e;

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] partial_q, partial_d;
  logic        negQuot_q, negQuot_d;
  logic        negRem_q, negRem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] aluResult;
  logic        isDiv;
  logic        isSigned;
  logic [31:0] absReg1;
  logic [31:0] absReg2;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] stepQuot;
  logic [31:0] stepRem;
  logic        stall;
  logic        whilo;

  always_comb begin
    aluResult = '0;
    case (ex.alusel_i)
      SEL_LOGIC: begin
        case (ex.aluop_i)
          OP_OR:   aluResult = ex.reg1_i | ex.reg2_i;
          OP_AND:  aluResult = ex.reg1_i & ex.reg2_i;
          OP_XOR:  aluResult = ex.reg1_i ^ ex.reg2_i;
          OP_NOR:  aluResult = ~(ex.reg1_i | ex.reg2_i);
          default: aluResult = '0;
        endcase
      end
      SEL_ARITH: begin
        case (ex.aluop_i)
          OP_ADDU: aluResult = ex.reg1_i + ex.reg2_i;
          OP_SUBU: aluResult = ex.reg1_i - ex.reg2_i;
          OP_SLT:  aluResult = {31'b0, $signed(ex.reg1_i) < $signed(ex.reg2_i)};
          OP_SLTU: aluResult = {31'b0, ex.reg1_i < ex.reg2_i};
          default: aluResult = '0;
        endcase
      end
      default: aluResult = '0;
    endcase
  end

  assign isDiv    = rst && ((ex.aluop_i == OP_DIV) || (ex.aluop_i == OP_DIVU));
  assign isSigned = (ex.aluop_i == OP_DIV);
  assign absReg1  = (isSigned && ex.reg1_i[31]) ? -ex.reg1_i : ex.reg1_i;
  assign absReg2  = (isSigned && ex.reg2_i[31]) ? -ex.reg2_i : ex.reg2_i;

  // Restoring step: shift the next dividend bit into the partial remainder and
  // keep the subtraction only when it does not go negative.
  assign shifted  = {partial_q, dividend_q[31]};
  assign trial    = shifted - {1'b0, divisor_q};
  assign stepQuot = {dividend_q[30:0], ~trial[32]};
  assign stepRem  = trial[32] ? shifted[31:0] : trial[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      partial_q  <= '0;
      negQuot_q  <= 1'b0;
      negRem_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      partial_q  <= partial_d;
      negQuot_q  <= negQuot_d;
      negRem_q   <= negRem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // A flush overrides every state: nothing stalls, nothing is written, and the
  // partially computed result is abandoned so hi/lo keep the previous result.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    partial_d  = partial_q;
    negQuot_d  = negQuot_q;
    negRem_d   = negRem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    stall      = 1'b0;
    whilo      = 1'b0;
    if (ex.flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (isDiv) begin
            stall      = 1'b1;
            dividend_d = absReg1;
            divisor_d  = absReg2;
            partial_d  = '0;
            negQuot_d  = isSigned && (ex.reg1_i[31] ^ ex.reg2_i[31]);
            negRem_d   = isSigned && ex.reg1_i[31];
            cnt_d      = '0;
            state_d    = (ex.reg2_i == 32'h0) ? DIV_ZERO : DIV_ON;
          end
        end
        DIV_ZERO: begin
          stall   = 1'b1;
          hi_d    = '0;
          lo_d    = '0;
          state_d = DIV_END;
        end
        DIV_ON: begin
          stall      = 1'b1;
          dividend_d = stepQuot;
          partial_d  = stepRem;
          cnt_d      = cnt_q + 5'd1;
          if (cnt_q == LAST_STEP) begin
            lo_d    = negQuot_q ? -stepQuot : stepQuot;
            hi_d    = negRem_q ? -stepRem : stepRem;
            state_d = DIV_END;
          end
        end
        DIV_END: begin
          whilo   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ex.wd_o       = rst ? ex.wd_i : 5'd0;
  assign ex.wreg_o     = rst && ex.wreg_i && !ex.flush_i;
  assign ex.wdata_o    = (rst && !ex.flush_i) ? aluResult : 32'h0;
  assign ex.whilo_o    = whilo;
  assign ex.hi_o       = hi_q;
  assign ex.lo_o       = lo_q;
  assign ex.stallreq_o = stall;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized scoreboard bench for ex_stage: the driver queues expected ALU and HI/LO results
// from an arithmetic reference model; a negedge monitor pops and compares them.
module tb_ex_stage;

  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } aluExp_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycle;
  } divExp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   passCount;
  int   totalCount;
  logic expStall;
  logic issueAlu;
  aluExp_t aluQ[$];
  divExp_t divQ[$];

  ex_stage_if bus ();

  ex_stage dut (
    .clk(clk),
    .rst(rst),
    .ex (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    else
      passCount++;
  endtask

  function automatic logic [31:0] refAlu(input logic [7:0] op, input logic [2:0] sel,
                                         input logic [31:0] a, input logic [31:0] b);
    if (sel == SEL_LOGIC) begin
      if (op == OP_OR)  return a | b;
      if (op == OP_AND) return a & b;
      if (op == OP_XOR) return a ^ b;
      if (op == OP_NOR) return ~(a | b);
    end else if (sel == SEL_ARITH) begin
      if (op == OP_ADDU) return a + b;
      if (op == OP_SUBU) return a - b;
      if (op == OP_SLT)  return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      if (op == OP_SLTU) return (a < b) ? 32'h1 : 32'h0;
    end
    return 32'h0;
  endfunction

  // Plain 64-bit division: truncation toward zero gives the required remainder sign,
  // and the wider type makes 0x80000000 / -1 wrap naturally in the low word.
  function automatic divExp_t refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    divExp_t r;
    longint x, y;
    r.cycle = 0;
    if (b == 32'h0) begin
      r.hi = 32'h0;
      r.lo = 32'h0;
      return r;
    end
    x = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    r.lo = 32'(x / y);
    r.hi = 32'(x % y);
    return r;
  endfunction

  task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] wd, input logic wreg,
                               input logic flush);
    aluExp_t e;
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = a;
    bus.reg2_i   = b;
    bus.wd_i     = wd;
    bus.wreg_i   = wreg;
    bus.flush_i  = flush;
    e.wd    = wd;
    e.wreg  = wreg & ~flush;
    e.wdata = flush ? 32'h0 : refAlu(op, sel, a, b);
    aluQ.push_back(e);
    issueAlu = 1'b1;
    expStall = 1'b0;
  endtask

  task automatic applyDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input int flushAt, input int resetAt);
    int n;
    divExp_t e;
    aluExp_t f;
    n = (b == 32'h0) ? 3 : 34;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      issueAlu    = 1'b0;
      bus.flush_i = 1'b0;
      if (k == 0) begin
        bus.aluop_i  = sgn ? OP_DIV : OP_DIVU;
        bus.alusel_i = SEL_NOP;
        bus.reg1_i   = a;
        bus.reg2_i   = b;
        bus.wd_i     = 5'($urandom);
        bus.wreg_i   = 1'b0;
        if (flushAt < 0 && resetAt < 0) begin
          e = refDiv(sgn, a, b);
          e.cycle = cyc + n - 1;
          divQ.push_back(e);
        end
      end else begin
        bus.reg1_i = $urandom;
        bus.reg2_i = $urandom;
      end
      expStall = (k < n - 1);
      if (k == flushAt) begin
        bus.flush_i = 1'b1;
        bus.wreg_i  = 1'b1;
        f.wd    = bus.wd_i;
        f.wreg  = 1'b0;
        f.wdata = 32'h0;
        aluQ.push_back(f);
        issueAlu = 1'b1;
        expStall = 1'b0;
        break;
      end
      if (k == resetAt) begin
        rst      = 1'b0;
        expStall = 1'b0;
        @(negedge clk);
        checkOutput("rst_wd", 32'(bus.wd_o), 32'h0);
        checkOutput("rst_wreg", 32'(bus.wreg_o), 32'h0);
        checkOutput("rst_wdata", bus.wdata_o, 32'h0);
        checkOutput("rst_whilo", 32'(bus.whilo_o), 32'h0);
        checkOutput("rst_hi", bus.hi_o, 32'h0);
        checkOutput("rst_lo", bus.lo_o, 32'h0);
        checkOutput("rst_stall", 32'(bus.stallreq_o), 32'h0);
        break;
      end
    end
  endtask

  // Monitor: stall is compared every active cycle; queued results are popped when presented.
  always @(negedge clk) begin
    if (rst) begin
      aluExp_t a;
      divExp_t d;
      checkOutput("stallreq", 32'(bus.stallreq_o), 32'(expStall));
      if (issueAlu) begin
        checkOutput("alu_queue_nonempty", 32'(aluQ.size() != 0), 32'h1);
        if (aluQ.size() != 0) begin
          a = aluQ.pop_front();
          checkOutput("wd", 32'(bus.wd_o), 32'(a.wd));
          checkOutput("wreg", 32'(bus.wreg_o), 32'(a.wreg));
          checkOutput("wdata", bus.wdata_o, a.wdata);
        end
      end
      if (divQ.size() == 0) begin
        checkOutput("whilo_unexpected", 32'(bus.whilo_o), 32'h0);
      end else if (bus.whilo_o) begin
        d = divQ.pop_front();
        checkOutput("div_latency", 32'(cyc), 32'(d.cycle));
        checkOutput("hi", bus.hi_o, d.hi);
        checkOutput("lo", bus.lo_o, d.lo);
      end
    end
  end

  initial begin
    logic [7:0]  ops [10];
    logic [2:0]  sels [3];
    logic [31:0] corners [6];
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a, b;
    ops = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU, 8'h00, 8'h3C};
    sels = '{SEL_LOGIC, SEL_ARITH, SEL_NOP};
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h7};
    cyc = 0;
    passCount = 0;
    totalCount = 0;
    expStall = 1'b0;
    issueAlu = 1'b0;
    rst = 1'b0;
    bus.aluop_i  = OP_DIVU;
    bus.alusel_i = SEL_NOP;
    bus.reg1_i   = 32'd50;
    bus.reg2_i   = 32'd3;
    bus.wd_i     = 5'd9;
    bus.wreg_i   = 1'b1;
    bus.flush_i  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_wd", 32'(bus.wd_o), 32'h0);
    checkOutput("reset_wreg", 32'(bus.wreg_o), 32'h0);
    checkOutput("reset_stall", 32'(bus.stallreq_o), 32'h0);
    checkOutput("reset_whilo", 32'(bus.whilo_o), 32'h0);
    checkOutput("reset_hilo", bus.hi_o | bus.lo_o, 32'h0);

    applyStimulus(OP_ADDU, SEL_ARITH, 32'hFFFFFFFF, 32'h2, 5'd5, 1'b1, 1'b0);
    applyStimulus(OP_SLT, SEL_ARITH, 32'hFFFFFFFF, 32'h1, 5'd6, 1'b1, 1'b0);
    applyStimulus(OP_SLTU, SEL_ARITH, 32'hFFFFFFFF, 32'h1, 5'd7, 1'b1, 1'b0);
    applyStimulus(OP_NOR, SEL_LOGIC, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op  = ops[$urandom_range(9)];
      sel = sels[$urandom_range(2)];
      a   = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : $urandom;
      b   = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : $urandom;
      applyStimulus(op, sel, a, b, 5'($urandom), 1'($urandom), ($urandom_range(7) == 0));
    end

    applyDiv(1'b0, 32'd100, 32'd7, -1, -1);
    applyDiv(1'b1, 32'hFFFFFFF9, 32'd2, -1, -1);
    applyDiv(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, -1);
    applyDiv(1'b1, 32'd5, 32'd0, -1, -1);
    applyDiv(1'b0, 32'd9, 32'd3, -1, -1);
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = ($urandom_range(3) == 0) ? 32'h0 : (($urandom_range(1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      applyDiv(1'($urandom), a, b, -1, -1);
    end

    applyDiv(1'b0, 32'd1000, 32'd7, 10, -1);
    applyStimulus(8'h00, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    applyDiv(1'b0, 32'd123456, 32'd11, -1, 20);
    applyStimulus(8'h00, SEL_NOP, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
    applyDiv(1'b0, 32'd1000, 32'd10, -1, -1);
    applyStimulus(OP_XOR, SEL_LOGIC, 32'hA5A5A5A5, 32'h0F0F0F0F, 5'd31, 1'b1, 1'b0);

    @(posedge clk);
    #1;
    issueAlu = 1'b0;
    bus.aluop_i = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("div_queue_drained", 32'(divQ.size()), 32'h0);
    checkOutput("alu_queue_drained", 32'(aluQ.size()), 32'h0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
